// File: rtl/tim_regs.sv
`default_nettype none
// ============================================================================
//  Module   : tim_regs
//  Purpose  : Memory-mapped control/status registers for the general-purpose
//             timer. Holds PSC/ARR preload and active (shadow) copies, the
//             enable/direction controls, and turns the core's asynchronous
//             reload pulse into a sticky update flag and a maskable irq.
//             Optional macro TIM_REGS_BUS_ERR_EN enables bus_err responses
//             for unmapped offsets, CNT writes and EGR reads.
//  Revision : 1.0 - initial release
// ============================================================================
module tim_regs #(
    parameter int          ADDR_W  = 5,
    parameter logic [15:0] ARR_RST = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_req,
    input  logic              bus_we,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [31:0]       bus_wdata,
    output logic              bus_ready,
    output logic [31:0]       bus_rdata,
    output logic              bus_err,
    output logic              tim_en,
    output logic              tim_countdown,
    output logic [15:0]       tim_psc,
    output logic [15:0]       tim_arr,
    input  logic [31:0]       timer_value,
    input  logic              timer_interrupt,
    output logic              irq
);

    localparam logic [2:0] c_slot_cr   = 3'd0;
    localparam logic [2:0] c_slot_psc  = 3'd1;
    localparam logic [2:0] c_slot_arr  = 3'd2;
    localparam logic [2:0] c_slot_sr   = 3'd3;
    localparam logic [2:0] c_slot_dier = 3'd4;
    localparam logic [2:0] c_slot_cnt  = 3'd5;
    localparam logic [2:0] c_slot_egr  = 3'd6;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic        cen_q, cen_d, dir_q, dir_d, arpe_q, arpe_d, uie_q, uie_d;
    logic        uif_q, uif_d, ovr_q, ovr_d, irq_q, irq_d;
    logic        en_q, en_d, cdir_q, cdir_d;
    logic        sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
    logic [15:0] psc_pre_q, psc_pre_d, arr_pre_q, arr_pre_d;
    logic [15:0] psc_act_q, psc_act_d, arr_act_q, arr_act_d;
    logic [31:0] rdata_q, rdata_d;

    logic        w_hi_zero;
    logic [2:0]  w_slot;
    logic        w_accept, w_wr, w_edge, w_upd, w_ug;
    logic        w_clr_uif, w_clr_ovr;
    logic [31:0] w_rmux;
    logic        w_unused;

    // Address bits above the 8-slot window must be zero for a hit.
    generate
        if (ADDR_W > 5) begin : g_hi_decode
            assign w_hi_zero = (bus_addr[ADDR_W-1:5] == '0);
        end else begin : g_no_hi
            assign w_hi_zero = 1'b1;
        end
    endgenerate

    assign w_slot    = bus_addr[4:2];
    assign w_accept  = (state_q == S_IDLE) && bus_req;
    assign w_wr      = w_accept && bus_we && w_hi_zero;
    assign w_edge    = sync2_q && !sync3_q;
    assign w_ug      = w_wr && (w_slot == c_slot_egr) && bus_wdata[0];
    assign w_upd     = w_edge || w_ug;
    assign w_clr_uif = w_wr && (w_slot == c_slot_sr) && bus_wdata[0];
    assign w_clr_ovr = w_wr && (w_slot == c_slot_sr) && bus_wdata[1];
    assign w_unused  = ^{bus_addr[1:0], bus_wdata[31:16]};

    // Read-data mux; preload registers are what software reads back.
    always_comb begin
        w_rmux = 32'd0;
        if (w_hi_zero) begin
            case (w_slot)
                c_slot_cr:   w_rmux = {24'd0, arpe_q, 5'd0, dir_q, cen_q};
                c_slot_psc:  w_rmux = {16'd0, psc_pre_q};
                c_slot_arr:  w_rmux = {16'd0, arr_pre_q};
                c_slot_sr:   w_rmux = {30'd0, ovr_q, uif_q};
                c_slot_dier: w_rmux = {31'd0, uie_q};
                c_slot_cnt:  w_rmux = timer_value;
                default:     w_rmux = 32'd0;
            endcase
        end
    end

    // Bus handshake FSM: accept in IDLE, respond for one cycle in RESP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus_req) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next-state for registers, shadow copies, flags and synchroniser.
    always_comb begin
        cen_d     = cen_q;
        dir_d     = dir_q;
        arpe_d    = arpe_q;
        uie_d     = uie_q;
        psc_pre_d = psc_pre_q;
        arr_pre_d = arr_pre_q;
        psc_act_d = psc_act_q;
        arr_act_d = arr_act_q;
        rdata_d   = 32'd0;
        sync1_d   = timer_interrupt;
        sync2_d   = sync1_q;
        sync3_d   = sync2_q;
        en_d      = cen_q;
        cdir_d    = dir_q;

        if (w_accept && !bus_we) rdata_d = w_rmux;

        if (w_wr) begin
            case (w_slot)
                c_slot_cr: begin
                    cen_d  = bus_wdata[0];
                    dir_d  = bus_wdata[1];
                    arpe_d = bus_wdata[7];
                end
                c_slot_psc:  psc_pre_d = bus_wdata[15:0];
                c_slot_arr:  arr_pre_d = bus_wdata[15:0];
                c_slot_dier: uie_d     = bus_wdata[0];
                default: ;
            endcase
        end

        // Stopped timer: shadows track preload. Running: PSC waits for an
        // update event, ARR waits only when auto-reload preload is on.
        if (!cen_q || w_upd) begin
            psc_act_d = psc_pre_q;
            arr_act_d = arr_pre_q;
        end else if (!arpe_q) begin
            arr_act_d = arr_pre_q;
        end

        // A set in the same cycle as a clear wins; OVR flags a lost update.
        ovr_d = w_clr_ovr ? 1'b0 : ovr_q;
        if (w_edge && uif_q && !w_clr_uif) ovr_d = 1'b1;
        uif_d = w_edge ? 1'b1 : (w_clr_uif ? 1'b0 : uif_q);
        irq_d = uif_d && uie_d;
    end

    // State and register storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cen_q     <= 1'b0;
            dir_q     <= 1'b0;
            arpe_q    <= 1'b0;
            uie_q     <= 1'b0;
            uif_q     <= 1'b0;
            ovr_q     <= 1'b0;
            irq_q     <= 1'b0;
            en_q      <= 1'b0;
            cdir_q    <= 1'b0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sync3_q   <= 1'b0;
            psc_pre_q <= 16'd0;
            arr_pre_q <= ARR_RST;
            psc_act_q <= 16'd0;
            arr_act_q <= ARR_RST;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            cen_q     <= cen_d;
            dir_q     <= dir_d;
            arpe_q    <= arpe_d;
            uie_q     <= uie_d;
            uif_q     <= uif_d;
            ovr_q     <= ovr_d;
            irq_q     <= irq_d;
            en_q      <= en_d;
            cdir_q    <= cdir_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            sync3_q   <= sync3_d;
            psc_pre_q <= psc_pre_d;
            arr_pre_q <= arr_pre_d;
            psc_act_q <= psc_act_d;
            arr_act_q <= arr_act_d;
            rdata_q   <= rdata_d;
        end
    end

`ifdef TIM_REGS_BUS_ERR_EN
    logic err_q, err_d;
    logic w_err;

    assign w_err = !w_hi_zero || (w_slot == 3'd7)
                 || (bus_we && (w_slot == c_slot_cnt))
                 || (!bus_we && (w_slot == c_slot_egr));

    // Error response is latched with the access and shown during RESP.
    always_comb begin
        err_d = 1'b0;
        if (w_accept) err_d = w_err;
    end

    // Error flag storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign bus_err = err_q;
`else
    assign bus_err = 1'b0;
`endif

    assign bus_ready     = (state_q == S_RESP);
    assign bus_rdata     = rdata_q;
    assign tim_en        = en_q;
    assign tim_countdown = cdir_q;
    assign tim_psc       = psc_act_q;
    assign tim_arr       = arr_act_q;
    assign irq           = irq_q;

endmodule
`default_nettype wire
